// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard/forwarding controller: tracks in-flight rd's, picks EX operand sources, raises ID stall.
// Build option FWD3_EN: when defined, WB-slot producers forward via FORWARD_3 instead of stalling.
module ex_hazard_ctrl #(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_inst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [2:0]        id_opa_select,
   input  logic [2:0]        id_opb_select,
   input  logic              id_cond_branch,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wr_en,
   input  logic              id_is_load,
   input  logic              ex_take_branch,
   output logic [2:0]        id_ex_opa_select,
   output logic [2:0]        id_ex_opb_select,
   output logic              id_ex_bubble,
   output logic              hz_stall
);

   localparam logic [2:0] ALU_OPA_IS_REGA = 3'd0;
   localparam logic [2:0] ALU_OPB_IS_REGB = 3'd0;
   localparam logic [2:0] FORWARD_1       = 3'd5;
   localparam logic [2:0] FORWARD_2       = 3'd6;
`ifdef FWD3_EN
   localparam logic [2:0] FORWARD_3       = 3'd7;
`endif

   logic              r_ex_v,  r_ex_wr,  r_ex_ld;
   logic              r_mem_v, r_mem_wr, r_mem_ld;
   logic              r_wb_v,  r_wb_wr;
   logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;

   logic w_rs1_ex, w_rs1_mem, w_rs1_wb;
   logic w_rs2_ex, w_rs2_mem, w_rs2_wb;
   logic w_ld_stall, w_br_stall, w_wb_stall;
   logic w_bubble;
   logic [2:0] w_opa, w_opb;

   // x0 is hard-wired zero, so it never counts as produced
   assign w_rs1_ex  = r_ex_v  & r_ex_wr  & (r_ex_rd  == id_rs1) & (id_rs1 != '0);
   assign w_rs1_mem = r_mem_v & r_mem_wr & (r_mem_rd == id_rs1) & (id_rs1 != '0);
   assign w_rs1_wb  = r_wb_v  & r_wb_wr  & (r_wb_rd  == id_rs1) & (id_rs1 != '0);
   assign w_rs2_ex  = r_ex_v  & r_ex_wr  & (r_ex_rd  == id_rs2) & (id_rs2 != '0);
   assign w_rs2_mem = r_mem_v & r_mem_wr & (r_mem_rd == id_rs2) & (id_rs2 != '0);
   assign w_rs2_wb  = r_wb_v  & r_wb_wr  & (r_wb_rd  == id_rs2) & (id_rs2 != '0);

   assign w_ld_stall = r_ex_ld & ((id_rs1_used & w_rs1_ex) | (id_rs2_used & w_rs2_ex));

   // branch compare reads the register file directly, so any in-flight producer blocks it
   assign w_br_stall = id_cond_branch &
                       (w_rs1_ex | w_rs1_mem | w_rs1_wb | w_rs2_ex | w_rs2_mem | w_rs2_wb);

`ifdef FWD3_EN
   assign w_wb_stall = 1'b0;
`else
   assign w_wb_stall = (id_rs1_used & w_rs1_wb & ~w_rs1_ex & ~w_rs1_mem) |
                       (id_rs2_used & w_rs2_wb & ~w_rs2_ex & ~w_rs2_mem);
`endif

   assign hz_stall = id_valid_inst & ~ex_take_branch & (w_ld_stall | w_br_stall | w_wb_stall);
   assign w_bubble = hz_stall | ex_take_branch | ~id_valid_inst;

   always_comb begin
      w_opa = id_opa_select;
      if (id_rs1_used) begin
         if (w_rs1_ex)       w_opa = FORWARD_1;
         else if (w_rs1_mem) w_opa = FORWARD_2;
`ifdef FWD3_EN
         else if (w_rs1_wb)  w_opa = FORWARD_3;
`endif
      end
   end

   always_comb begin
      w_opb = id_opb_select;
      if (id_rs2_used) begin
         if (w_rs2_ex)       w_opb = FORWARD_1;
         else if (w_rs2_mem) w_opb = FORWARD_2;
`ifdef FWD3_EN
         else if (w_rs2_wb)  w_opb = FORWARD_3;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_v   <= 1'b0;
         r_ex_wr  <= 1'b0;
         r_ex_ld  <= 1'b0;
         r_ex_rd  <= '0;
         r_mem_v  <= 1'b0;
         r_mem_wr <= 1'b0;
         r_mem_ld <= 1'b0;
         r_mem_rd <= '0;
         r_wb_v   <= 1'b0;
         r_wb_wr  <= 1'b0;
         r_wb_rd  <= '0;
         id_ex_opa_select <= ALU_OPA_IS_REGA;
         id_ex_opb_select <= ALU_OPB_IS_REGB;
         id_ex_bubble     <= 1'b1;
      end else begin
         r_wb_v   <= r_mem_v;
         r_wb_wr  <= r_mem_wr;
         r_wb_rd  <= r_mem_rd;
         r_mem_v  <= r_ex_v;
         r_mem_wr <= r_ex_wr;
         r_mem_ld <= r_ex_ld;
         r_mem_rd <= r_ex_rd;
         id_ex_bubble <= w_bubble;
         if (w_bubble) begin
            r_ex_v   <= 1'b0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= '0;
            id_ex_opa_select <= ALU_OPA_IS_REGA;
            id_ex_opb_select <= ALU_OPB_IS_REGB;
         end else begin
            r_ex_v   <= 1'b1;
            r_ex_wr  <= id_wr_en;
            r_ex_ld  <= id_is_load;
            r_ex_rd  <= id_rd;
            id_ex_opa_select <= w_opa;
            id_ex_opb_select <= w_opb;
         end
      end
   end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Hazard and forwarding controller for the execute stage. It tracks the destination registers of in-flight instructions. From that it produces the registered operand-select codes that drive the EX operand muxes: register, PC, zero, immediate, 4, or forward paths 1, 2 and 3. It also raises the ID stall for load-use and conditional-branch operand hazards, and inserts bubbles on stall or taken branch. It sits between decode and the ID/EX pipeline register.

Parameters:
REG_AW, 5, register address width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_valid_inst  in  1  instruction in ID is valid
id_rs1  in  REG_AW  source register 1
id_rs2  in  REG_AW  source register 2
id_rs1_used  in  1  opa comes from rs1 (decoder opa choice is register)
id_rs2_used  in  1  opb comes from rs2 (decoder opb choice is register)
id_opa_select  in  3  decoder's opa choice (ALU_OPA_* code)
id_opb_select  in  3  decoder's opb choice (ALU_OPB_* code)
id_cond_branch  in  1  ID holds a conditional branch (reads rs1 and rs2 unforwarded)
id_rd  in  REG_AW  destination register
id_wr_en  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
ex_take_branch  in  1  taken-branch indication from EX
id_ex_opa_select  out  3  registered opa select to EX
id_ex_opb_select  out  3  registered opb select to EX
id_ex_bubble  out  1  registered: the instruction entering EX is killed
hz_stall  out  1  combinational: hold PC and IF/ID this cycle

Behaviour:
- Reset: asynchronous and active-high. The following are forced while rst=1:
  - id_ex_opa_select = ALU_OPA_IS_REGA (default code) and id_ex_opb_select = ALU_OPB_IS_REGB.
  - id_ex_bubble = 1.
  - All tracker entries invalid.
- Tracker: a 3-entry shift register, slots EX, MEM and WB. Each entry holds {valid, wr, load, rd}.
  - Every cycle: WB<=MEM, MEM<=EX.
  - EX<=ID entry, or an invalid entry when the issued instruction is bubbled.
  - The pipeline never stalls below ID, so the tracker always shifts.
- Producer match: a slot matches source register rs when valid & wr & rd==rs & rs!=0. Register x0 never forwards or stalls.
- Forward select for each operand whose *_used=1:
  - EX-slot match: FORWARD_1.
  - Otherwise MEM-slot match: FORWARD_2.
  - Otherwise WB-slot match: FORWARD_3.
  - Otherwise the decoder code passes through.
  - The youngest producer wins.
- When *_used=0, the decoder code (PC, ZR, IMM, 4) passes through unchanged.
- Load-use stall: EX-slot match with load=1 on a used operand gives hz_stall=1 for 1 cycle.
  - The next cycle the producer is in MEM and FORWARD_2 is selected; the mem_wb forward path carries load data.
- Branch stall: the branch compare uses unforwarded register values.
  - When id_cond_branch=1 and rs1 or rs2 matches any slot (EX, MEM or WB), hz_stall=1.
  - The stall holds until no slot matches. Worst case is 3 cycles.
- Bubble rule: the issued entry is invalid and id_ex_bubble=1 next cycle when any of the following holds: hz_stall, ex_take_branch, or !id_valid_inst.
- A bubbled issue registers default select codes.
- ex_take_branch has priority over hz_stall:
  - hz_stall is forced to 0, so IF refetches the target.
  - The ID instruction is squashed and never enters the tracker.
- Latency: select and bubble outputs are registered, 1 cycle after ID evaluation. hz_stall is combinational in the same cycle.
- Simultaneous matches on rs1 and rs2 resolve independently, so opa and opb may use different forward paths.

Optional Feature:
Macro FWD3_EN.
- Defined: a WB-slot match selects FORWARD_3, as above.
- Undefined: FORWARD_3 is never emitted. A WB-slot match that is not covered by an EX or MEM match gives hz_stall=1 for 1 cycle, and the register file supplies the value afterwards.
- Branch-stall behaviour is the same in both builds.

Test Plan:
- Forward from EX slot: issue add x5 (wr), then add x6,x5,x5 the next cycle -> opa=opb=FORWARD_1, hz_stall=0.
- Forward distances 2 and 3: producer of x7, then one independent instruction, then a consumer of x7 -> FORWARD_2. With two independent instructions between -> FORWARD_3 (FWD3_EN defined); with FWD3_EN undefined -> 1-cycle stall, then the decoder code.
- Load-use: lw x8 then add x9,x8,x0 -> hz_stall=1 for exactly 1 cycle, id_ex_bubble=1, then opa=FORWARD_2.
- x0 and non-register operands: producer writes x0, consumer reads x0 -> no forward or stall. Consumer with opa=PC and producer rd matching rs1 -> opa=ALU_OPA_IS_PC.
- Branch: addi x3, then beq x3,x4 -> stall for 3 cycles (EX, MEM, WB matches), then issue with no bubble. ex_take_branch during a stall -> hz_stall=0, bubble=1.
- Reset: assert rst asynchronously mid-stream -> outputs become defaults and bubble=1 immediately. After release, an old rd never forwards.
